// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RISC-V style datapath sharing one memory port.
// It sequences fetch/decode/execute/writeback, counts retired instructions and traps on faults.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode_i,
  input  logic        Zero_i,
  input  logic        Mem_Ready_i,
  output logic        PC_Write_o,
  output logic        IR_Write_o,
  output logic        Reg_Write_o,
  output logic        Mem_Read_o,
  output logic        Mem_Write_o,
  output logic        IorD_o,
  output logic        PC_Src_o,
  output logic [1:0]  ALU_Src_A_o,
  output logic [1:0]  ALU_Src_B_o,
  output logic [2:0]  ALU_Op_o,
  output logic [1:0]  Mem_to_Reg_o,
  output logic [3:0]  State_o,
  output logic        Error_o,
  output logic [1:0]  Error_Code_o,
  output logic [31:0] Instret_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_ALU_WB   = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_LOAD_WB  = 4'd7;
  localparam logic [3:0] S_MEM_WR   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_LUI      = 4'd11;
  localparam logic [3:0] S_ERROR    = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [3:0]  state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] instret_q, instret_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;
  logic        waiting;
  logic        timeout;
  logic [3:0]  st;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = waiting && !Mem_Ready_i && (wait_q == WAIT_LIMIT);

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    err_d     = err_q;
    code_d    = code_q;
    case (state_q)
      S_FETCH:  if (Mem_Ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode_i)
          OP_R:               state_d = S_EXEC_R;
          OP_I:               state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          OP_JAL:             state_d = S_JAL;
          OP_LUI:             state_d = S_LUI;
          default: begin
            state_d = S_ERROR;
            err_d   = 1'b1;
            code_d  = 2'b01;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (Opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (Mem_Ready_i) state_d = S_LOAD_WB;
      S_MEM_WR: begin
        if (Mem_Ready_i) begin
          state_d   = S_FETCH;
          instret_d = instret_q + 32'd1;
        end
      end
      S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JAL: begin
        state_d   = S_FETCH;
        instret_d = instret_q + 32'd1;
      end
      S_ERROR: state_d = S_ERROR;
      default: begin
        state_d = S_ERROR;
        err_d   = 1'b1;
        code_d  = 2'b01;
      end
    endcase
    // Ready on the final allowed cycle is a normal completion, so timeout only fires without it.
    if (timeout) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
      code_d  = 2'b10;
    end
    wait_d = (waiting && (state_d == state_q) && !Mem_Ready_i) ? wait_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      instret_q <= 32'd0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  // While reset is held the decode behaves as FETCH with the commit strobes suppressed.
  assign st = reset ? S_FETCH : state_q;

  always_comb begin
    PC_Write_o   = 1'b0;
    IR_Write_o   = 1'b0;
    Reg_Write_o  = 1'b0;
    Mem_Read_o   = 1'b0;
    Mem_Write_o  = 1'b0;
    IorD_o       = 1'b0;
    PC_Src_o     = 1'b0;
    ALU_Src_A_o  = 2'd0;
    ALU_Src_B_o  = 2'd0;
    ALU_Op_o     = 3'b000;
    Mem_to_Reg_o = 2'd0;
    case (st)
      S_FETCH: begin
        Mem_Read_o  = 1'b1;
        ALU_Src_B_o = 2'd1;
        IR_Write_o  = Mem_Ready_i && !reset;
        PC_Write_o  = Mem_Ready_i && !reset;
      end
      S_DECODE: begin
        ALU_Src_A_o = 2'd2;
        ALU_Src_B_o = 2'd2;
      end
      S_EXEC_R: begin
        ALU_Src_A_o = 2'd1;
        ALU_Op_o    = 3'b010;
      end
      S_EXEC_I: begin
        ALU_Src_A_o = 2'd1;
        ALU_Src_B_o = 2'd2;
        ALU_Op_o    = 3'b011;
      end
      S_LUI: begin
        ALU_Src_B_o = 2'd2;
        ALU_Op_o    = 3'b100;
      end
      S_ALU_WB: Reg_Write_o = 1'b1;
      S_MEM_ADDR: begin
        ALU_Src_A_o = 2'd1;
        ALU_Src_B_o = 2'd2;
      end
      S_MEM_RD: begin
        Mem_Read_o = 1'b1;
        IorD_o     = 1'b1;
      end
      S_LOAD_WB: begin
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = 2'd1;
      end
      S_MEM_WR: begin
        Mem_Write_o = 1'b1;
        IorD_o      = 1'b1;
      end
      S_BRANCH: begin
        ALU_Src_A_o = 2'd1;
        ALU_Op_o    = 3'b001;
        PC_Src_o    = 1'b1;
        PC_Write_o  = !Zero_i;
      end
      S_JAL: begin
        PC_Write_o   = 1'b1;
        PC_Src_o     = 1'b1;
        Reg_Write_o  = 1'b1;
        Mem_to_Reg_o = 2'd2;
      end
      default: ;
    endcase
  end

  assign State_o      = st;
  assign Error_o      = err_q;
  assign Error_Code_o = code_q;
  assign Instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction stream against a per-instruction trace model,
// plus directed fault, timeout and reset scenarios.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Opcode_i;
  logic        Zero_i;
  logic        Mem_Ready_i;
  logic        PC_Write_o, IR_Write_o, Reg_Write_o, Mem_Read_o, Mem_Write_o;
  logic        IorD_o, PC_Src_o;
  logic [1:0]  ALU_Src_A_o, ALU_Src_B_o, Mem_to_Reg_o;
  logic [2:0]  ALU_Op_o;
  logic [3:0]  State_o;
  logic        Error_o;
  logic [1:0]  Error_Code_o;
  logic [31:0] Instret_o;

  int          total = 0;
  int          bad = 0;
  logic [31:0] instret_m = 32'd0;
  logic        exp_err = 1'b0;
  logic [1:0]  exp_code = 2'b00;

  multicycle_control #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .Opcode_i(Opcode_i), .Zero_i(Zero_i), .Mem_Ready_i(Mem_Ready_i),
    .PC_Write_o(PC_Write_o), .IR_Write_o(IR_Write_o), .Reg_Write_o(Reg_Write_o),
    .Mem_Read_o(Mem_Read_o), .Mem_Write_o(Mem_Write_o), .IorD_o(IorD_o), .PC_Src_o(PC_Src_o),
    .ALU_Src_A_o(ALU_Src_A_o), .ALU_Src_B_o(ALU_Src_B_o), .ALU_Op_o(ALU_Op_o),
    .Mem_to_Reg_o(Mem_to_Reg_o), .State_o(State_o), .Error_o(Error_o),
    .Error_Code_o(Error_Code_o), .Instret_o(Instret_o)
  );

  always #5 clk = ~clk;

  wire [22:0] dut_vec = {State_o, PC_Write_o, IR_Write_o, Reg_Write_o, Mem_Read_o, Mem_Write_o,
                         IorD_o, PC_Src_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Mem_to_Reg_o,
                         Error_o, Error_Code_o};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control-word table written straight from the state descriptions.
  function automatic logic [22:0] exp_out(input logic [3:0] st, input logic rdy, input logic z,
                                          input logic e, input logic [1:0] c);
    logic pcw, irw, rw, mr, mw, iord, pcs;
    logic [1:0] a, b, m2r;
    logic [2:0] op;
    {pcw, irw, rw, mr, mw, iord, pcs} = 7'b0;
    a = 2'd0; b = 2'd0; m2r = 2'd0; op = 3'b000;
    case (st)
      4'd0:  begin mr = 1; b = 2'd1; irw = rdy; pcw = rdy; end
      4'd1:  begin a = 2'd2; b = 2'd2; end
      4'd2:  begin a = 2'd1; op = 3'b010; end
      4'd3:  begin a = 2'd1; b = 2'd2; op = 3'b011; end
      4'd4:  rw = 1;
      4'd5:  begin a = 2'd1; b = 2'd2; end
      4'd6:  begin mr = 1; iord = 1; end
      4'd7:  begin rw = 1; m2r = 2'd1; end
      4'd8:  begin mw = 1; iord = 1; end
      4'd9:  begin a = 2'd1; op = 3'b001; pcs = 1; pcw = ~z; end
      4'd10: begin pcw = 1; pcs = 1; rw = 1; m2r = 2'd2; end
      4'd11: begin b = 2'd2; op = 3'b100; end
      default: ;
    endcase
    return {st, pcw, irw, rw, mr, mw, iord, pcs, a, b, op, m2r, e, c};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive inputs just after the edge, compare settled outputs, advance.
  task automatic step(input logic [3:0] st, input logic rdy, input logic z);
    Mem_Ready_i = rdy;
    Zero_i      = z;
    #2;
    check($sformatf("state%0d_ctl", st), 32'(dut_vec), 32'(exp_out(st, rdy, z, exp_err, exp_code)));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Mem_Ready_i = 1'b1;
    Zero_i = 1'b0;
    @(posedge clk);
    #3;
    check("reset_ctl", 32'(dut_vec), 32'(exp_out(4'd0, 1'b0, 1'b0, 1'b0, 2'b00)));
    check("reset_instret", Instret_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    instret_m = 32'd0;
    exp_err = 1'b0;
    exp_code = 2'b00;
  endtask

  // Expected cycle trace of one instruction derived from its opcode class and wait delays.
  task automatic run_instr(input logic [6:0] opc, input logic z, input int df, input int dm);
    Opcode_i = opc;
    for (int i = 0; i < df; i++) step(4'd0, 1'b0, rb());
    step(4'd0, 1'b1, rb());
    step(4'd1, rb(), rb());
    case (opc)
      7'h33: begin step(4'd2, rb(), rb());  step(4'd4, rb(), rb()); end
      7'h13: begin step(4'd3, rb(), rb());  step(4'd4, rb(), rb()); end
      7'h37: begin step(4'd11, rb(), rb()); step(4'd4, rb(), rb()); end
      7'h03: begin
        step(4'd5, rb(), rb());
        for (int i = 0; i < dm; i++) step(4'd6, 1'b0, rb());
        step(4'd6, 1'b1, rb());
        step(4'd7, rb(), rb());
      end
      7'h23: begin
        step(4'd5, rb(), rb());
        for (int i = 0; i < dm; i++) step(4'd8, 1'b0, rb());
        step(4'd8, 1'b1, rb());
      end
      7'h63: step(4'd9, rb(), z);
      default: step(4'd10, rb(), rb());
    endcase
    instret_m = instret_m + 32'd1;
    check("instret", Instret_o, instret_m);
    $display("instr opc=%b zero=%b fetch_wait=%0d mem_wait=%0d instret=%0d",
             opc, z, df, dm, Instret_o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ops [7];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37};
    reset = 1'b1;
    Opcode_i = 7'h13;
    Zero_i = 1'b0;
    Mem_Ready_i = 1'b0;
    #1;
    do_reset();

    run_instr(7'h13, 1'b0, 0, 0);
    run_instr(7'h03, 1'b0, 0, 3);
    run_instr(7'h63, 1'b0, 0, 0);
    run_instr(7'h63, 1'b1, 0, 0);
    run_instr(7'h6F, 1'b0, 0, 0);
    run_instr(7'h33, 1'b0, 15, 0);
    run_instr(7'h03, 1'b0, 0, 15);
    run_instr(7'h23, 1'b0, 2, 15);

    for (int n = 0; n < 40; n++) begin
      int df, dm;
      df = (($urandom_range(0, 7)) == 0) ? 15 : int'($urandom_range(0, 4));
      dm = (($urandom_range(0, 7)) == 0) ? 15 : int'($urandom_range(0, 4));
      run_instr(ops[$urandom_range(0, 6)], rb(), df, dm);
    end

    // Reset in the middle of a store wait abandons it without retiring.
    Opcode_i = 7'h23;
    step(4'd0, 1'b1, 1'b0);
    step(4'd1, 1'b0, 1'b0);
    step(4'd5, 1'b0, 1'b0);
    repeat (3) step(4'd8, 1'b0, 1'b0);
    reset = 1'b1;
    Mem_Ready_i = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    Mem_Ready_i = 1'b0;
    instret_m = 32'd0;
    #2;
    check("rst_mid_wr_state", 32'(State_o), 32'd0);
    check("rst_mid_wr_instret", Instret_o, 32'd0);
    check("rst_mid_wr_memwrite", 32'(Mem_Write_o), 32'd0);
    @(posedge clk);
    #1;
    run_instr(7'h37, 1'b0, 0, 0);

    // Illegal opcode traps and holds until reset.
    Opcode_i = 7'h7F;
    step(4'd0, 1'b1, 1'b0);
    step(4'd1, rb(), 1'b0);
    exp_err = 1'b1;
    exp_code = 2'b01;
    repeat (10) step(4'd15, rb(), rb());
    do_reset();
    run_instr(7'h13, 1'b0, 0, 0);

    // Fetch that never completes times out after 16 cycles.
    Opcode_i = 7'h13;
    repeat (16) step(4'd0, 1'b0, 1'b0);
    exp_err = 1'b1;
    exp_code = 2'b10;
    repeat (3) step(4'd15, rb(), rb());
    do_reset();

    // Load data phase that never completes also times out.
    Opcode_i = 7'h03;
    step(4'd0, 1'b1, 1'b0);
    step(4'd1, 1'b0, 1'b0);
    step(4'd5, 1'b0, 1'b0);
    repeat (16) step(4'd6, 1'b0, 1'b0);
    exp_err = 1'b1;
    exp_code = 2'b10;
    repeat (2) step(4'd15, rb(), rb());
    do_reset();
    run_instr(7'h23, 1'b0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
